// File: rtl/laser_pkg.sv
// Shared types and constants for the framed laser transmitter.
// Lane FSM states, the idle line level and the frame parity helper.
package laser_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } lane_state_t;

   localparam logic LASER_IDLE_LEVEL = 1'b1;
   localparam int   MAX_DATA_W       = 16;

   // Even parity: the parity bit makes the total count of ones even.
   function automatic logic even_parity(input logic [MAX_DATA_W-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/laser_tx_lane.sv
// One laser lane: accepts a word on valid/ready and serialises it as a
// start/data/parity/stop frame timed by a free-standing baud counter.
module laser_tx_lane
   import laser_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int BAUD_DIV  = 8,
   parameter int PARITY_EN = 1,
   parameter int STOP_BITS = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              en,
   input  logic [DATA_W-1:0] data,
   input  logic              valid,
   output logic              ready,
   output logic              line,
   output logic              busy,
   output logic              done
);

   localparam int BAUD_W = $clog2(BAUD_DIV);
   localparam int BIT_W  = $clog2(DATA_W + 1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
   localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

   lane_state_t       state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic              stop_q, stop_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              parity_q, parity_d;
   logic              line_q, line_d;
   logic              armed_q;
   logic              period_end;
   logic              accept;

   // armed_q holds data_ready low while reset is held and for one cycle after.
   assign ready      = en && armed_q && (state_q == IDLE);
   assign accept     = ready && valid;
   assign period_end = (baud_q == BAUD_LAST);
   assign line       = line_q;
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == STOP) && period_end && (stop_q == STOP_LAST);

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d  = state_q;
      baud_d   = period_end ? '0 : baud_q + 1'b1;
      bit_d    = bit_q;
      stop_d   = stop_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      line_d   = LASER_IDLE_LEVEL;

      case (state_q)
         IDLE: begin
            baud_d = '0;
            if (accept) begin
               state_d  = START;
               shift_d  = data;
               parity_d = even_parity(MAX_DATA_W'(data));
               bit_d    = '0;
               stop_d   = 1'b0;
            end
         end
         START:  if (period_end) state_d = DATA;
         DATA: begin
            if (period_end) begin
               if (bit_q == BIT_LAST) begin
                  state_d = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + 1'b1;
               end
            end
         end
         PARITY: if (period_end) state_d = STOP;
         STOP: begin
            if (period_end) begin
               if (stop_q == STOP_LAST) state_d = IDLE;
               else                     stop_d  = stop_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // The line level is computed from next-state values so laser_out is a flop.
      case (state_d)
         START:   line_d = ~LASER_IDLE_LEVEL;
         DATA:    line_d = shift_d[0];
         PARITY:  line_d = parity_q;
         default: line_d = LASER_IDLE_LEVEL;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         // NOTE: the shift register is tiny, so it is reset too; this keeps the datapath free of X after reset.
         state_q  <= IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         stop_q   <= 1'b0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         line_q   <= LASER_IDLE_LEVEL;
         armed_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         stop_q   <= stop_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         line_q   <= line_d;
         armed_q  <= 1'b1;
      end
   end

endmodule

// File: rtl/laser_frame_tx.sv
// Multi-channel framed laser transmitter: NUM_CH independent lanes, each
// driving a differential GPIO pair {~line, line}.
module laser_frame_tx
   import laser_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int DATA_W    = 8,
   parameter int BAUD_DIV  = 8,
   parameter int PARITY_EN = 1,
   parameter int STOP_BITS = 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     en,
   input  logic [NUM_CH*DATA_W-1:0] data_in,
   input  logic [NUM_CH-1:0]        data_valid,
   output logic [NUM_CH-1:0]        data_ready,
   output logic [2*NUM_CH-1:0]      laser_out,
   output logic [NUM_CH-1:0]        busy,
   output logic [NUM_CH-1:0]        done
);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      logic line;

      laser_tx_lane #(
         .DATA_W   (DATA_W),
         .BAUD_DIV (BAUD_DIV),
         .PARITY_EN(PARITY_EN),
         .STOP_BITS(STOP_BITS)
      ) u_lane (
         .clock(clock),
         .reset(reset),
         .en   (en),
         .data (data_in[c*DATA_W +: DATA_W]),
         .valid(data_valid[c]),
         .ready(data_ready[c]),
         .line (line),
         .busy (busy[c]),
         .done (done[c])
      );

      assign laser_out[2*c +: 2] = {~line, line};
   end

endmodule

// File: tb/tb_laser_frame_tx.sv
// Scoreboard bench for laser_frame_tx: two configurations, per-cycle expected
// line/done levels queued by a frame-level reference model.
module tb_laser_frame_tx;

   localparam int NP = 3;   // ports 0,1: dut_a lanes; port 2: dut_b lane 0
   localparam int CFG_DW [NP] = '{8, 8, 5};
   localparam int CFG_BD [NP] = '{4, 4, 2};
   localparam int CFG_PE [NP] = '{1, 1, 0};
   localparam int CFG_SB [NP] = '{1, 1, 2};

   typedef struct packed {
      logic line;
      logic done;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        en_a  = 1'b0;
   logic        en_b  = 1'b0;
   logic [15:0] word [NP];
   logic        vld  [NP];

   logic [1:0]  ready_a, busy_a, done_a;
   logic [3:0]  laser_a;
   logic [0:0]  ready_b, busy_b, done_b;
   logic [1:0]  laser_b;

   logic obs_line [NP], obs_inv [NP], obs_busy [NP], obs_done [NP], obs_ready [NP];

   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;
   bit   model_armed = 1'b0;
   exp_t q [NP][$];

   always #5 clock = ~clock;

   laser_frame_tx #(
      .NUM_CH(2), .DATA_W(8), .BAUD_DIV(4), .PARITY_EN(1), .STOP_BITS(1)
   ) dut_a (
      .clock     (clock),
      .reset     (reset),
      .en        (en_a),
      .data_in   ({word[1][7:0], word[0][7:0]}),
      .data_valid({vld[1], vld[0]}),
      .data_ready(ready_a),
      .laser_out (laser_a),
      .busy      (busy_a),
      .done      (done_a)
   );

   laser_frame_tx #(
      .NUM_CH(1), .DATA_W(5), .BAUD_DIV(2), .PARITY_EN(0), .STOP_BITS(2)
   ) dut_b (
      .clock     (clock),
      .reset     (reset),
      .en        (en_b),
      .data_in   (word[2][4:0]),
      .data_valid(vld[2]),
      .data_ready(ready_b),
      .laser_out (laser_b),
      .busy      (busy_b),
      .done      (done_b)
   );

   always_comb begin
      for (int c = 0; c < 2; c++) begin
         obs_line[c]  = laser_a[2*c];
         obs_inv[c]   = laser_a[2*c+1];
         obs_busy[c]  = busy_a[c];
         obs_done[c]  = done_a[c];
         obs_ready[c] = ready_a[c];
      end
      obs_line[2]  = laser_b[0];
      obs_inv[2]   = laser_b[1];
      obs_busy[2]  = busy_b[0];
      obs_done[2]  = done_b[0];
      obs_ready[2] = ready_b[0];
   end

   function automatic logic en_of(int p);
      return (p < 2) ? en_a : en_b;
   endfunction

   task automatic check(string name, int p, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s port %0d cycle %0d: got %b, expected %b", name, p, cycle, act, exp);
      end
   endtask

   // Reference frame: start 0, data LSB first, optional even parity, stop 1s;
   // each bit held for one baud period, done on the very last cycle.
   task automatic push_frame(int p, logic [15:0] w);
      int   bits [$];
      int   ones = 0;
      exp_t e;
      bits.push_back(0);
      for (int i = 0; i < CFG_DW[p]; i++) begin
         bits.push_back(int'(w[i]));
         ones += int'(w[i]);
      end
      if (CFG_PE[p] != 0) bits.push_back(ones % 2);
      for (int s = 0; s < CFG_SB[p]; s++) bits.push_back(1);
      for (int k = 0; k < bits.size(); k++) begin
         for (int r = 0; r < CFG_BD[p]; r++) begin
            e.line = (bits[k] != 0);
            e.done = (k == bits.size() - 1) && (r == CFG_BD[p] - 1);
            q[p].push_back(e);
         end
      end
   endtask

   // Model: a lane is free only once its whole frame has been played out.
   always @(posedge clock) begin
      cycle++;
      if (reset) begin
         for (int p = 0; p < NP; p++) q[p].delete();
         model_armed = 1'b0;
      end else begin
         for (int p = 0; p < NP; p++) begin
            if (q[p].size() != 0) void'(q[p].pop_front());
            else if (en_of(p) && model_armed && vld[p]) push_frame(p, word[p]);
         end
         model_armed = 1'b1;
      end
   end

   // Monitor: compares every output of every port mid-cycle.
   always @(negedge clock) begin
      for (int p = 0; p < NP; p++) begin
         logic exp_line, exp_done, exp_busy, exp_ready;
         exp_busy  = (q[p].size() != 0);
         exp_line  = exp_busy ? q[p][0].line : 1'b1;
         exp_done  = exp_busy ? q[p][0].done : 1'b0;
         exp_ready = en_of(p) && model_armed && !exp_busy;
         check("line",  p, obs_line[p],  exp_line);
         check("pair",  p, obs_inv[p],   ~obs_line[p]);
         check("busy",  p, obs_busy[p],  exp_busy);
         check("done",  p, obs_done[p],  exp_done);
         check("ready", p, obs_ready[p], exp_ready);
      end
   end

   task automatic step(int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   initial begin
      for (int p = 0; p < NP; p++) begin
         word[p] = '0;
         vld[p]  = 1'b0;
      end
      step(3);
      reset = 1'b0;
      en_a  = 1'b1;
      step(2);

      // 0x08 on lane 0, then 0x17 on lane 1 two cycles later.
      word[0] = 16'h08; vld[0] = 1'b1;
      step(1);
      vld[0] = 1'b0;
      step(1);
      word[1] = 16'h17; vld[1] = 1'b1;
      step(1);
      vld[1] = 1'b0;
      word[0] = 16'hFF; word[1] = 16'h00;   // ignored while busy
      step(55);

      // Back-to-back frames 0xA5 then 0x5A on lane 0.
      word[0] = 16'hA5; vld[0] = 1'b1;
      step(1);
      word[0] = 16'h5A;
      step(46);
      vld[0] = 1'b0;
      step(50);

      // Enable low holds off a pending word; drop enable mid-frame.
      en_a = 1'b0; word[0] = 16'h33; vld[0] = 1'b1;
      step(10);
      en_a = 1'b1;
      step(1);
      step(10);
      en_a = 1'b0;
      step(60);
      vld[0] = 1'b0;
      en_a   = 1'b1;
      step(2);

      // Reset mid-frame, then a clean 0x3C frame.
      word[0] = 16'hC3; vld[0] = 1'b1;
      step(1);
      vld[0] = 1'b0;
      step(19);
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      step(2);
      word[0] = 16'h3C; vld[0] = 1'b1;
      step(1);
      vld[0] = 1'b0;
      step(50);

      // Second configuration: 5-bit word, no parity, two stop bits.
      en_b = 1'b1;
      word[2] = 16'h15; vld[2] = 1'b1;
      step(1);
      vld[2] = 1'b0;
      step(20);

      // Randomised traffic on all ports, with one reset in the middle.
      for (int i = 0; i < 800; i++) begin
         en_a = ($urandom_range(0, 9) != 0);
         en_b = ($urandom_range(0, 9) != 0);
         for (int p = 0; p < NP; p++) begin
            vld[p]  = ($urandom_range(0, 3) != 0);
            word[p] = 16'($urandom);
         end
         reset = (i == 400 || i == 401);
         step(1);
      end

      reset = 1'b0;
      en_a  = 1'b1;
      en_b  = 1'b1;
      for (int p = 0; p < NP; p++) vld[p] = 1'b0;
      step(80);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
